// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - LSB, fetch and byte-wide RAM bus bundle for mem_ctrl
interface mem_ctrl_if;
    logic        lsb_in_config;
    logic        lsb_in_ls;
    logic [31:0] lsb_in_addr;
    logic [31:0] lsb_in_data;
    logic [2:0]  lsb_in_precise;
    logic [3:0]  lsb_in_rob;
    logic        lsb_out_config;
    logic [31:0] lsb_out_data;
    logic [3:0]  lsb_out_rob;
    logic        if_in_config;
    logic [31:0] if_in_addr;
    logic        if_out_config;
    logic [31:0] if_out_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport slave (
        input  lsb_in_config, lsb_in_ls, lsb_in_addr, lsb_in_data, lsb_in_precise, lsb_in_rob,
        input  if_in_config, if_in_addr, mem_din,
        output lsb_out_config, lsb_out_data, lsb_out_rob,
        output if_out_config, if_out_data, mem_dout, mem_a, mem_wr
    );

    modport master (
        output lsb_in_config, lsb_in_ls, lsb_in_addr, lsb_in_data, lsb_in_precise, lsb_in_rob,
        output if_in_config, if_in_addr, mem_din,
        input  lsb_out_config, lsb_out_data, lsb_out_rob,
        input  if_out_config, if_out_data, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial load/store/fetch sequencer over an 8-bit RAM bus
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    input  logic      io_buffer_full,
    mem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  precise_q;
    logic        src_lsb;
    logic [23:0] asm_q;
    logic [31:0] a_q;
    logic [7:0]  dout_q;
    logic        wr_q;
    logic        lsb_cfg_q;
    logic [31:0] lsb_data_q;
    logic [3:0]  rob_q;
    logic        if_cfg_q;
    logic [31:0] if_data_q;

    logic        io_blocked;
    logic        take_lsb;
    logic        req_live;
    logic [1:0]  last_cnt;
    logic        at_last;
    logic [31:0] next_a;
    logic [7:0]  store_byte;
    logic [31:0] load_word;

    // IO-space stores wait while the IO write buffer is full; fetch may go instead
    assign io_blocked = ~bus.lsb_in_ls & (bus.lsb_in_addr[17:16] == 2'b11) & io_buffer_full;
    assign take_lsb   = bus.lsb_in_config & ~io_blocked;
    assign req_live   = src_lsb ? bus.lsb_in_config : bus.if_in_config;
    assign at_last    = (cnt == last_cnt);
    assign next_a     = addr_q + {30'd0, cnt} + 32'd1;

    // Index of the final byte for the latched access size (1, 2 or 4 bytes)
    always_comb begin
        last_cnt = 2'd3;
        case (precise_q[1:0])
            2'b00:   last_cnt = 2'd0;
            2'b01:   last_cnt = 2'd1;
            default: last_cnt = 2'd3;
        endcase
    end

    // Next little-endian store byte, following the one currently on the bus
    always_comb begin
        store_byte = data_q[7:0];
        case (cnt)
            2'd0:    store_byte = data_q[15:8];
            2'd1:    store_byte = data_q[23:16];
            2'd2:    store_byte = data_q[31:24];
            default: store_byte = data_q[7:0];
        endcase
    end

    // Final load value: earlier bytes from the assembly register, last byte straight off mem_din
    always_comb begin
        load_word = {bus.mem_din, asm_q};
        case (precise_q)
            3'b000:  load_word = {{24{bus.mem_din[7]}}, bus.mem_din};
            3'b100:  load_word = {24'd0, bus.mem_din};
            3'b001:  load_word = {{16{bus.mem_din[7]}}, bus.mem_din, asm_q[7:0]};
            3'b101:  load_word = {16'd0, bus.mem_din, asm_q[7:0]};
            default: load_word = {bus.mem_din, asm_q};
        endcase
    end

    // Request sequencer; rdy low freezes every register including the response pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            precise_q  <= 3'd0;
            src_lsb    <= 1'b0;
            asm_q      <= 24'd0;
            a_q        <= 32'd0;
            dout_q     <= 8'd0;
            wr_q       <= 1'b0;
            lsb_cfg_q  <= 1'b0;
            lsb_data_q <= 32'd0;
            rob_q      <= 4'd0;
            if_cfg_q   <= 1'b0;
            if_data_q  <= 32'd0;
        end else if (rdy) begin
            lsb_cfg_q <= 1'b0;
            if_cfg_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take_lsb) begin
                        src_lsb   <= 1'b1;
                        rob_q     <= bus.lsb_in_rob;
                        precise_q <= bus.lsb_in_precise;
                        addr_q    <= bus.lsb_in_addr;
                        data_q    <= bus.lsb_in_data;
                        a_q       <= bus.lsb_in_addr;
                        cnt       <= 2'd0;
                        if (bus.lsb_in_ls) begin
                            wr_q  <= 1'b0;
                            state <= READ;
                        end else begin
                            dout_q <= bus.lsb_in_data[7:0];
                            wr_q   <= 1'b1;
                            state  <= WRITE;
                        end
                    end else if (bus.if_in_config) begin
                        src_lsb   <= 1'b0;
                        precise_q <= 3'b010;
                        addr_q    <= bus.if_in_addr;
                        a_q       <= bus.if_in_addr;
                        wr_q      <= 1'b0;
                        cnt       <= 2'd0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (!req_live) begin
                        state <= IDLE;
                    end else begin
                        case (cnt)
                            2'd0:    asm_q[7:0]   <= bus.mem_din;
                            2'd1:    asm_q[15:8]  <= bus.mem_din;
                            2'd2:    asm_q[23:16] <= bus.mem_din;
                            default: ;
                        endcase
                        if (!at_last) begin
                            a_q <= next_a;
                            cnt <= cnt + 2'd1;
                        end else begin
                            if (src_lsb) begin
                                lsb_cfg_q  <= 1'b1;
                                lsb_data_q <= load_word;
                            end else begin
                                if_cfg_q  <= 1'b1;
                                if_data_q <= load_word;
                            end
                            state <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (!at_last) begin
                        a_q    <= next_a;
                        dout_q <= store_byte;
                        cnt    <= cnt + 2'd1;
                    end else begin
                        wr_q       <= 1'b0;
                        lsb_cfg_q  <= 1'b1;
                        lsb_data_q <= 32'd0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_a          = a_q;
    assign bus.mem_dout       = dout_q;
    assign bus.mem_wr         = wr_q & rdy;
    assign bus.lsb_out_config = lsb_cfg_q;
    assign bus.lsb_out_data   = lsb_data_q;
    assign bus.lsb_out_rob    = rob_q;
    assign bus.if_out_config  = if_cfg_q;
    assign bus.if_out_data    = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed vector bench for mem_ctrl
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic io_buffer_full = 1'b0;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];

    // read data for the address registered on the previous edge
    assign bus.mem_din = ram[bus.mem_a[11:0]];

    always @(posedge clk) begin
        if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
    end

    typedef struct {
        logic        ls;
        logic [2:0]  precise;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  rob;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_lsb(input vec_t v);
        bus.lsb_in_config  = 1'b1;
        bus.lsb_in_ls      = v.ls;
        bus.lsb_in_precise = v.precise;
        bus.lsb_in_addr    = v.addr;
        bus.lsb_in_data    = v.data;
        bus.lsb_in_rob     = v.rob;
    endtask

    task automatic run_lsb(input vec_t v, input string tag);
        int lat;
        logic [31:0] got_data;
        logic [3:0]  got_rob;
        logic        got_wr;
        logic [31:0] shifted;
        lat = -1;
        got_data = 32'hx;
        got_rob = 4'hx;
        got_wr = 1'bx;
        drive_lsb(v);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.lsb_out_config) begin
                lat = c;
                got_data = bus.lsb_out_data;
                got_rob = bus.lsb_out_rob;
                got_wr = bus.mem_wr;
                break;
            end
            if (c < v.exp_lat) begin
                chk({tag, " mem_a"}, bus.mem_a, v.addr + c);
                if (!v.ls) begin
                    shifted = v.data >> (8 * c);
                    chk({tag, " mem_wr"}, {31'd0, bus.mem_wr}, 32'd1);
                    chk({tag, " mem_dout"}, {24'd0, bus.mem_dout}, {24'd0, shifted[7:0]});
                end
            end
        end
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " data"}, got_data, v.exp_data);
        chk({tag, " rob"}, {28'd0, got_rob}, {28'd0, v.rob});
        if (!v.ls) chk({tag, " wr_end"}, {31'd0, got_wr}, 32'd0);
        bus.lsb_in_config = 1'b0;
        @(posedge clk); #1;
        chk({tag, " pulse_one_cycle"}, {31'd0, bus.lsb_out_config}, 32'd0);
    endtask

    initial begin
        int lsb_seen;
        int if_seen;
        int overlap;
        int pulses;
        int wr_seen;
        logic [31:0] if_got;
        logic [31:0] lsb_got;
        vec_t tmp;

        bus.lsb_in_config  = 1'b0;
        bus.lsb_in_ls      = 1'b0;
        bus.lsb_in_addr    = 32'd0;
        bus.lsb_in_data    = 32'd0;
        bus.lsb_in_precise = 3'd0;
        bus.lsb_in_rob     = 4'd0;
        bus.if_in_config   = 1'b0;
        bus.if_in_addr     = 32'd0;

        for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        #1;
        ram[12'h100] <= 8'h78; ram[12'h101] <= 8'h56; ram[12'h102] <= 8'h34; ram[12'h103] <= 8'h12;
        ram[12'h104] <= 8'hEF; ram[12'h105] <= 8'hBE;
        ram[12'h110] <= 8'h80;
        ram[12'h120] <= 8'h01; ram[12'h121] <= 8'h80;
        ram[12'h130] <= 8'h7F;
        ram[12'h202] <= 8'h5A;
        ram[12'h211] <= 8'h77;
        ram[12'h300] <= 8'hBE; ram[12'h301] <= 8'hBA; ram[12'h302] <= 8'hFE; ram[12'h303] <= 8'hCA;

        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'h0,        4'd3,  32'h12345678, 4};
        vecs[1]  = '{1'b1, 3'b000, 32'h110, 32'h0,        4'd5,  32'hFFFFFF80, 1};
        vecs[2]  = '{1'b1, 3'b100, 32'h110, 32'h0,        4'd6,  32'h00000080, 1};
        vecs[3]  = '{1'b1, 3'b001, 32'h120, 32'h0,        4'd7,  32'hFFFF8001, 2};
        vecs[4]  = '{1'b1, 3'b101, 32'h120, 32'h0,        4'd8,  32'h00008001, 2};
        vecs[5]  = '{1'b1, 3'b000, 32'h130, 32'h0,        4'd9,  32'h0000007F, 1};
        vecs[6]  = '{1'b1, 3'b001, 32'h101, 32'h0,        4'd10, 32'h00003456, 2};
        vecs[7]  = '{1'b1, 3'b010, 32'h102, 32'h0,        4'd11, 32'hBEEF1234, 4};
        vecs[8]  = '{1'b0, 3'b001, 32'h200, 32'hAABBCCDD, 4'd12, 32'h0,        2};
        vecs[9]  = '{1'b0, 3'b000, 32'h210, 32'h12345699, 4'd13, 32'h0,        1};
        vecs[10] = '{1'b0, 3'b010, 32'h220, 32'h01020304, 4'd14, 32'h0,        4};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_a", bus.mem_a, 32'd0);
        chk("reset mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("reset lsb_out_config", {31'd0, bus.lsb_out_config}, 32'd0);
        chk("reset if_out_config", {31'd0, bus.if_out_config}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("idle lsb_out_data", bus.lsb_out_data, 32'd0);

        // table-driven loads and stores
        for (int i = 0; i < 11; i++) run_lsb(vecs[i], $sformatf("vec%0d", i));

        chk("sh byte0", {24'd0, ram[12'h200]}, 32'hDD);
        chk("sh byte1", {24'd0, ram[12'h201]}, 32'hCC);
        chk("sh byte2 untouched", {24'd0, ram[12'h202]}, 32'h5A);
        chk("sb byte0", {24'd0, ram[12'h210]}, 32'h99);
        chk("sb byte1 untouched", {24'd0, ram[12'h211]}, 32'h77);
        chk("sw word", {ram[12'h223], ram[12'h222], ram[12'h221], ram[12'h220]}, 32'h01020304);

        // LSB and fetch together: LSB first, fetch accepted at E_len+2
        tmp = '{1'b1, 3'b000, 32'h110, 32'h0, 4'd1, 32'hFFFFFF80, 1};
        drive_lsb(tmp);
        bus.if_in_config = 1'b1;
        bus.if_in_addr   = 32'h300;
        lsb_seen = -1; if_seen = -1; overlap = 0;
        if_got = 32'hx; lsb_got = 32'hx;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (bus.lsb_out_config && bus.if_out_config) overlap++;
            if (bus.lsb_out_config && lsb_seen < 0) begin
                lsb_seen = c; lsb_got = bus.lsb_out_data; bus.lsb_in_config = 1'b0;
            end
            if (bus.if_out_config && if_seen < 0) begin
                if_seen = c; if_got = bus.if_out_data; bus.if_in_config = 1'b0;
                break;
            end
        end
        bus.lsb_in_config = 1'b0;
        bus.if_in_config = 1'b0;
        @(posedge clk); #1;
        chk("arb lsb latency", lsb_seen, 1);
        chk("arb lsb data", lsb_got, 32'hFFFFFF80);
        chk("arb fetch latency", if_seen, 7);
        chk("arb fetch data", if_got, 32'hCAFEBABE);
        chk("arb overlap", overlap, 0);

        // abort during 2nd byte of LW, new request accepted next cycle
        tmp = '{1'b1, 3'b010, 32'h100, 32'h0, 4'd2, 32'h12345678, 4};
        drive_lsb(tmp);
        pulses = 0;
        @(posedge clk); #1;
        if (bus.lsb_out_config) pulses++;
        @(posedge clk); #1;
        if (bus.lsb_out_config) pulses++;
        chk("abort mem_a before drop", bus.mem_a, 32'h101);
        bus.lsb_in_config = 1'b0;
        @(posedge clk); #1;
        if (bus.lsb_out_config) pulses++;
        chk("abort no pulse", pulses, 0);
        tmp = '{1'b1, 3'b000, 32'h130, 32'h0, 4'd4, 32'h0000007F, 1};
        run_lsb(tmp, "after_abort");

        // IO store held off while the IO buffer is full
        io_buffer_full = 1'b1;
        tmp = '{1'b0, 3'b000, 32'h30000, 32'h11, 4'd1, 32'h0, 1};
        drive_lsb(tmp);
        wr_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.mem_wr) wr_seen++;
        end
        chk("io blocked mem_wr", wr_seen, 0);
        io_buffer_full = 1'b0;
        @(posedge clk); #1;
        chk("io accept mem_wr", {31'd0, bus.mem_wr}, 32'd1);
        chk("io accept mem_a", bus.mem_a, 32'h30000);
        chk("io accept mem_dout", {24'd0, bus.mem_dout}, 32'h11);
        @(posedge clk); #1;
        chk("io pulse", {31'd0, bus.lsb_out_config}, 32'd1);
        bus.lsb_in_config = 1'b0;
        @(posedge clk); #1;

        // mem_wr gated by rdy during a store
        tmp = '{1'b0, 3'b000, 32'h240, 32'h55, 4'd6, 32'h0, 1};
        drive_lsb(tmp);
        @(posedge clk); #1;
        chk("rdy store mem_wr on", {31'd0, bus.mem_wr}, 32'd1);
        rdy = 1'b0;
        #1;
        chk("rdy store mem_wr gated", {31'd0, bus.mem_wr}, 32'd0);
        @(posedge clk); #1;
        chk("rdy store no write", {24'd0, ram[12'h240]}, 32'h00);
        chk("rdy store no pulse", {31'd0, bus.lsb_out_config}, 32'd0);
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("rdy store pulse", {31'd0, bus.lsb_out_config}, 32'd1);
        chk("rdy store written", {24'd0, ram[12'h240]}, 32'h55);
        bus.lsb_in_config = 1'b0;
        @(posedge clk); #1;

        // rdy low 3 cycles mid-READ
        tmp = '{1'b1, 3'b010, 32'h100, 32'h0, 4'd9, 32'h12345678, 4};
        drive_lsb(tmp);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rdy hold mem_a %0d", c), bus.mem_a, 32'h101);
        end
        rdy = 1'b1;
        lsb_seen = -1; lsb_got = 32'hx;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.lsb_out_config) begin
                lsb_seen = c; lsb_got = bus.lsb_out_data;
                break;
            end
        end
        chk("rdy resume latency", lsb_seen, 3);
        chk("rdy resume data", lsb_got, 32'h12345678);
        bus.lsb_in_config = 1'b0;
        @(posedge clk); #1;

        // reset mid-WRITE
        tmp = '{1'b0, 3'b010, 32'h400, 32'h01020304, 4'd5, 32'h0, 4};
        drive_lsb(tmp);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rstw pre mem_a", bus.mem_a, 32'h401);
        rst = 1'b0;
        #1;
        chk("rstw mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rstw mem_a", bus.mem_a, 32'd0);
        chk("rstw mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rstw lsb_out_rob", {28'd0, bus.lsb_out_rob}, 32'd0);
        chk("rstw if_out_data", bus.if_out_data, 32'd0);
        bus.lsb_in_config = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.lsb_out_config || bus.if_out_config || bus.mem_wr) pulses++;
        end
        chk("rstw no activity after", pulses, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
